// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory boot loader.
package imem_loader_pkg;

    localparam int unsigned LEN_W      = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;

    // Load session states; encodings are fixed so they stay stable across tools.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    // True while a frame is being received (rx_ready and busy are high).
    function automatic logic in_session(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

    // True in the states where a start request opens a new session.
    function automatic logic can_start(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream big-endian into words; first byte of a group lands in
// the most significant byte. The completed word is held until the next one.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_byte_valid,
    input  logic              i_clear,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid,
    output logic [1:0]        o_byte_idx
);

    localparam int unsigned SH_W = BYTE_W * (WORD_BYTES - 1);

    logic [SH_W-1:0]   r_shift;
    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_word;
    logic              r_word_valid;

    // Shift in accepted bytes; publish the word and a one-cycle strobe on the 4th byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_shift <= '0;
                r_idx   <= '0;
            end else if (i_byte_valid) begin
                r_shift <= {r_shift[SH_W-BYTE_W-1:0], i_byte};
                r_idx   <= r_idx + 2'd1;
                if (r_idx == 2'(WORD_BYTES - 1)) begin
                    r_word       <= {r_shift, i_byte};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_byte_idx   = r_idx;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed program (16-bit word count, big-endian words,
// XOR checksum) over a valid/ready byte interface, writes it to instruction
// memory at sequential word addresses and holds the core in reset until a
// load completes successfully.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_wadr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [BYTE_W-1:0]  r_csum;
    logic [31:0]        r_wadr;
    logic               r_rx_ready;
    logic               r_busy;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_err;

    logic               w_xfer;
    logic               w_start;
    logic               w_pack_valid;
    logic               w_word_done;
    logic               w_last_word;
    logic [LEN_W-1:0]   w_len_full;
    logic [WORD_W-1:0]  w_word;
    logic               w_word_valid;
    logic [1:0]         w_byte_idx;

    assign w_xfer       = rx_valid & r_rx_ready;
    assign w_start      = start & can_start(r_state);
    assign w_pack_valid = w_xfer & (r_state == DATA);
    assign w_word_done  = w_pack_valid & (w_byte_idx == 2'(WORD_BYTES - 1));
    assign w_last_word  = (r_word_cnt == r_len - 16'd1);
    assign w_len_full   = {r_len[LEN_W-1:BYTE_W], rx_data};

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (rx_data),
        .i_byte_valid (w_pack_valid),
        .i_clear      (w_start),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_byte_idx   (w_byte_idx)
    );

    // Next-state decode; transitions only on start or an accepted byte.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) w_state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (w_xfer) w_state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (w_xfer) begin
                    if ((w_len_full == '0) || (32'(w_len_full) > MAX_WORDS))
                        w_state_nxt = ERR;
                    else
                        w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_word_done && w_last_word) w_state_nxt = CSUM;
            end
            CSUM: begin
                if (w_xfer) w_state_nxt = (rx_data == r_csum) ? DONE : ERR;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, length/word counters, checksum, write address and status outputs.
    // Status flags are registered from the next state so they change in the
    // cycle right after the deciding byte is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_csum     <= '0;
            r_wadr     <= '0;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= in_session(w_state_nxt);
            r_busy     <= in_session(w_state_nxt);
            r_cpu_hold <= (w_state_nxt != DONE);
            r_done     <= (w_state_nxt == DONE);
            r_err      <= (w_state_nxt == ERR);

            if (w_start) begin
                r_len      <= '0;
                r_word_cnt <= '0;
                r_csum     <= '0;
            end

            if (w_xfer && (r_state == LEN_HI)) r_len[LEN_W-1:BYTE_W] <= rx_data;
            if (w_xfer && (r_state == LEN_LO)) r_len[BYTE_W-1:0]     <= rx_data;

            if (w_pack_valid) r_csum <= r_csum ^ rx_data;

            // Address is latched alongside the packed word so both appear with the strobe.
            if (w_word_done) begin
                r_wadr     <= BASE_ADR + {14'd0, r_word_cnt, 2'b00};
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = w_word_valid;
    assign imem_wadr  = r_wadr;
    assign imem_wdata = w_word;
    assign cpu_hold   = r_cpu_hold;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Two instances share the stimulus: one
// at base address 0, one at 0xFFFF_FFFC to exercise address wrap.
module tb_imem_loader;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        a_rx_ready, a_we, a_hold, a_busy, a_done, a_err;
    logic [31:0] a_wadr, a_wdata;
    logic        b_rx_ready, b_we, b_hold, b_busy, b_done, b_err;
    logic [31:0] b_wadr, b_wdata;

    imem_loader #(.BASE_ADR(BASE_A), .MAX_WORDS(256)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (a_rx_ready),
        .imem_we    (a_we),
        .imem_wadr  (a_wadr),
        .imem_wdata (a_wdata),
        .cpu_hold   (a_hold),
        .busy       (a_busy),
        .done       (a_done),
        .err        (a_err)
    );

    imem_loader #(.BASE_ADR(BASE_B), .MAX_WORDS(256)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (b_rx_ready),
        .imem_we    (b_we),
        .imem_wadr  (b_wadr),
        .imem_wdata (b_wdata),
        .cpu_hold   (b_hold),
        .busy       (b_busy),
        .done       (b_done),
        .err        (b_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard of expected memory writes: word index and data.
    typedef struct {
        int unsigned k;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    // Frame vectors: length field, words sent, checksum corruption, gap, expected status.
    typedef struct {
        logic [15:0] len;
        int unsigned nwords;
        logic [7:0]  csum_flip;
        int unsigned max_gap;
        logic        exp_done;
        logic        exp_err;
    } vec_t;
    vec_t vecs[7];

    logic [31:0] words[3];

    // Every write strobe must match the next scoreboard entry on both instances.
    always @(negedge clk) begin
        if (a_we === 1'b1 || b_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_imem_we actual we_a=%0b we_b=%0b required=no write", a_we, b_we);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("we_a", 32'(a_we), 32'd1);
                check("we_b", 32'(b_we), 32'd1);
                check("wadr_a", a_wadr, BASE_A + 32'(4 * e.k));
                check("wadr_b", b_wadr, BASE_B + 32'(4 * e.k));
                check("wdata_a", a_wdata, e.data);
                check("wdata_b", b_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        int unsigned gap;
        logic accepted;
        gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
        for (int unsigned i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            accepted = a_rx_ready && b_rx_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL rx_ready_timeout actual=0 required=1");
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 32'(a_rx_ready), 32'd0);
        check({tag, "_we"},       32'(a_we),       32'd0);
        check({tag, "_wadr_a"},   a_wadr,          32'd0);
        check({tag, "_wadr_b"},   b_wadr,          32'd0);
        check({tag, "_wdata"},    a_wdata,         32'd0);
        check({tag, "_cpu_hold"}, 32'(a_hold),     32'd1);
        check({tag, "_busy"},     32'(a_busy),     32'd0);
        check({tag, "_done"},     32'(a_done),     32'd0);
        check({tag, "_err"},      32'(a_err),      32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy",     32'(a_busy),     32'd1);
        check("start_rx_ready", 32'(a_rx_ready), 32'd1);
        check("start_done_clr", 32'(a_done),     32'd0);
        check("start_err_clr",  32'(a_err),      32'd0);
        check("start_cpu_hold", 32'(a_hold),     32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0]  cs;
        logic [7:0]  bt;
        logic [31:0] w;
        cs = 8'h00;
        pulse_start();
        send_byte(v.len[15:8], v.max_gap);
        send_byte(v.len[7:0], v.max_gap);
        for (int unsigned k = 0; k < v.nwords; k++) begin
            w = words[k];
            for (int b = 0; b < 4; b++) begin
                bt = w[31 - 8 * b -: 8];
                cs = cs ^ bt;
                if (b == 3) sb.push_back('{k, w});
                send_byte(bt, v.max_gap);
            end
        end
        if (v.nwords > 0) send_byte(cs ^ v.csum_flip, v.max_gap);
        check("end_done_a",     32'(a_done),     32'(v.exp_done));
        check("end_err_a",      32'(a_err),      32'(v.exp_err));
        check("end_cpu_hold_a", 32'(a_hold),     32'(!v.exp_done));
        check("end_busy_a",     32'(a_busy),     32'd0);
        check("end_rx_ready_a", 32'(a_rx_ready), 32'd0);
        check("end_done_b",     32'(b_done),     32'(v.exp_done));
        check("end_err_b",      32'(b_err),      32'(v.exp_err));
        for (int i = 0; i < 3; i++) tick();
        check("writes_drained", 32'(sb.size()), 32'd0);
        check("status_sticky_done", 32'(a_done), 32'(v.exp_done));
        check("status_sticky_err",  32'(a_err),  32'(v.exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Words from the reference frame; their XOR checksum is 0x8C.
        words[0] = 32'h2008_0005;
        words[1] = 32'hAC09_0004;
        words[2] = 32'h1234_5678;

        vecs[0] = '{16'h0002, 2, 8'h00, 0, 1'b1, 1'b0};
        vecs[1] = '{16'h0002, 2, 8'h00, 5, 1'b1, 1'b0};
        vecs[2] = '{16'h0002, 2, 8'h0D, 0, 1'b0, 1'b1};
        vecs[3] = '{16'h0002, 2, 8'h00, 3, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 0, 8'h00, 0, 1'b0, 1'b1};
        vecs[5] = '{16'h0101, 0, 8'h00, 2, 1'b0, 1'b1};
        vecs[6] = '{16'h0003, 3, 8'h00, 2, 1'b1, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        check_reset_vals("rst_hold");
        reset = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        check_reset_vals("rst_idle");

        // Bytes offered in IDLE must not be taken.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 3; i++) tick();
        rx_valid = 1'b0;
        check("idle_no_accept_busy", 32'(a_busy), 32'd0);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset after the 2nd byte of word 1: word 0 written, nothing afterwards.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        sb.push_back('{0, words[0]});
        for (int b = 0; b < 4; b++) begin
            logic [31:0] w0;
            w0 = words[0];
            send_byte(w0[31 - 8 * b -: 8], 0);
        end
        send_byte(8'hAC, 0);
        send_byte(8'h09, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        reset    = 1'b1;
        #1;
        check("midrst_busy",     32'(a_busy),     32'd0);
        check("midrst_rx_ready", 32'(a_rx_ready), 32'd0);
        check("midrst_cpu_hold", 32'(a_hold),     32'd1);
        for (int i = 0; i < 3; i++) tick();
        rx_valid = 1'b0;
        check_reset_vals("midrst");
        reset = 1'b0;
        tick();
        check("midrst_writes_drained", 32'(sb.size()), 32'd0);
        run_frame(vecs[0]);

        // Start while a session is active is ignored; the frame still completes.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h00, 0);
        start = 1'b1;
        send_byte(8'h01, 0);
        sb.push_back('{0, words[2]});
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        start = 1'b0;
        send_byte(8'h78, 0);
        send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78, 0);
        check("busy_start_ignored_done", 32'(a_done), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("busy_start_drained", 32'(sb.size()), 32'd0);

        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
